// File: rtl/integ_pkg.sv
// Shared types and constants for the gyro integrator sequencer.
package integ_pkg;

  typedef enum logic [2:0] {
    WAIT_INIT,
    START,
    CAL,
    RUN,
    ERR
  } seq_state_t;

  localparam int          SPD_W        = 11;
  localparam logic [19:0] CAL_TMO_FAST = 20'd4095;
  localparam logic [15:0] STALE_FAST   = 16'd255;
  localparam logic [10:0] FUS_ON_DEF   = 11'h200;
  localparam logic [10:0] FUS_OFF_DEF  = 11'h180;
  localparam logic [4:0]  COAST_DEF    = 5'd16;

  // Simulation builds swap the long hardware timeouts for short fixed ones.
  function automatic logic [19:0] cal_lim(input bit fast, input logic [19:0] tmo);
    return fast ? CAL_TMO_FAST : tmo;
  endfunction

  function automatic logic [15:0] stale_lim(input bit fast, input logic [15:0] cyc);
    return fast ? STALE_FAST : cyc;
  endfunction

endpackage

// File: rtl/integ_sequencer_if.sv
// Control/status bundle between motion logic, the integrator and the sequencer.
interface integ_sequencer_if;
  logic                       gyro_ok;
  logic                       cal_req;
  logic                       go;
  logic [integ_pkg::SPD_W-1:0] frwrd_spd;
  logic                       cal_done;
  logic                       rdy;
  logic                       strt_cal;
  logic                       moving;
  logic                       en_fusion;
  logic                       cal_busy;
  logic                       cal_err;
  logic                       hdg_vld;

  modport master (
    output gyro_ok, cal_req, go, frwrd_spd, cal_done, rdy,
    input  strt_cal, moving, en_fusion, cal_busy, cal_err, hdg_vld
  );

  modport slave (
    input  gyro_ok, cal_req, go, frwrd_spd, cal_done, rdy,
    output strt_cal, moving, en_fusion, cal_busy, cal_err, hdg_vld
  );
endinterface

// File: rtl/hyst_cmp.sv
// Registered hysteresis comparator: sets at/above on_th, clears below off_th,
// holds in between, forced low while disabled.
module hyst_cmp #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] val,
  input  logic [W-1:0] on_th,
  input  logic [W-1:0] off_th,
  output logic         q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                q <= 1'b0;
    else if (!en)           q <= 1'b0;
    else if (val >= on_th)  q <= 1'b1;
    else if (val < off_th)  q <= 1'b0;
  end

endmodule

// File: rtl/integ_sequencer.sv
// Sequences gyro calibration, gates integration/fusion in RUN and watches the
// integrator's rdy stream for staleness.
module integ_sequencer
  import integ_pkg::*;
#(
  parameter bit          FAST_SIM    = 1'b1,
  parameter logic [19:0] CAL_TMO     = 20'hFFFFF,
  parameter logic [15:0] STALE_CYC   = 16'hFFFF,
  parameter logic [10:0] FUS_ON      = FUS_ON_DEF,
  parameter logic [10:0] FUS_OFF     = FUS_OFF_DEF,
  parameter logic [4:0]  COAST_SMPLS = COAST_DEF
) (
  input logic              clk,
  input logic              rst,
  integ_sequencer_if.slave bus
);

  localparam logic [19:0] TMO_LIM   = cal_lim(FAST_SIM, CAL_TMO);
  localparam logic [15:0] STALE_LIM = stale_lim(FAST_SIM, STALE_CYC);

  seq_state_t  state;
  logic [19:0] tmo_cnt, tmo_inc;
  logic [15:0] stale_cnt, stale_inc;
  logic [4:0]  coast_cnt;
  logic        strt_cal, moving, cal_busy, cal_err, hdg_vld;
  logic        fus_en, en_fusion;

  // tmo_cnt counts clocks since START began; the limit is hit on the edge
  // where the count reaches it, so the exits below compare the next value.
  assign tmo_inc   = (tmo_cnt == TMO_LIM)     ? tmo_cnt   : tmo_cnt + 20'd1;
  assign stale_inc = (stale_cnt == STALE_LIM) ? stale_cnt : stale_cnt + 16'd1;
  assign fus_en    = (state == RUN) && bus.go && !bus.cal_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_INIT;
      tmo_cnt   <= '0;
      stale_cnt <= '0;
      coast_cnt <= '0;
      strt_cal  <= 1'b0;
      moving    <= 1'b0;
      cal_busy  <= 1'b0;
      cal_err   <= 1'b0;
      hdg_vld   <= 1'b0;
    end else begin
      strt_cal <= 1'b0;
      case (state)
        WAIT_INIT: if (bus.gyro_ok) begin
          state    <= START;
          strt_cal <= 1'b1;
          tmo_cnt  <= '0;
        end
        START: begin
          state    <= CAL;
          cal_busy <= 1'b1;
          tmo_cnt  <= tmo_inc;
        end
        CAL: begin
          if (bus.cal_done) begin
            state     <= RUN;
            cal_busy  <= 1'b0;
            hdg_vld   <= 1'b1;
            stale_cnt <= '0;
            coast_cnt <= '0;
            moving    <= 1'b0;
          end else begin
            tmo_cnt <= tmo_inc;
            if (tmo_inc == TMO_LIM) begin
              state    <= ERR;
              cal_busy <= 1'b0;
              cal_err  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.cal_req) begin
            state     <= START;
            strt_cal  <= 1'b1;
            tmo_cnt   <= '0;
            stale_cnt <= '0;
            coast_cnt <= '0;
            moving    <= 1'b0;
            hdg_vld   <= 1'b0;
          end else begin
            if (bus.rdy) begin
              stale_cnt <= '0;
              hdg_vld   <= 1'b1;
            end else begin
              stale_cnt <= stale_inc;
              if (stale_inc == STALE_LIM) hdg_vld <= 1'b0;
            end
            // Keeping the coast count loaded while go is high makes a go
            // re-assert mid-coast restart the full coast window.
            if (bus.go) begin
              moving    <= 1'b1;
              coast_cnt <= COAST_SMPLS;
            end else if (moving && bus.rdy) begin
              if (coast_cnt <= 5'd1) begin
                coast_cnt <= '0;
                moving    <= 1'b0;
              end else begin
                coast_cnt <= coast_cnt - 5'd1;
              end
            end
          end
        end
        ERR: if (bus.cal_req) begin
          state    <= START;
          strt_cal <= 1'b1;
          cal_err  <= 1'b0;
          tmo_cnt  <= '0;
        end
        default: state <= WAIT_INIT;
      endcase
    end
  end

  hyst_cmp #(.W(SPD_W)) u_fus (
    .clk    (clk),
    .rst    (rst),
    .en     (fus_en),
    .val    (bus.frwrd_spd),
    .on_th  (FUS_ON),
    .off_th (FUS_OFF),
    .q      (en_fusion)
  );

  assign bus.strt_cal  = strt_cal;
  assign bus.moving    = moving;
  assign bus.en_fusion = en_fusion;
  assign bus.cal_busy  = cal_busy;
  assign bus.cal_err   = cal_err;
  assign bus.hdg_vld   = hdg_vld;

endmodule

// File: tb/tb_integ_sequencer.sv
// Directed + randomized bench for integ_sequencer against a phase/event model.
module tb_integ_sequencer;

  localparam int TMO   = 4095;
  localparam int STALE = 255;
  localparam int COAST = 16;
  localparam int FON   = 'h200;
  localparam int FOFF  = 'h180;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  integ_sequencer_if bus();

  integ_sequencer #(.FAST_SIM(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus elapsed-time / event counts since the
  // moments the rules refer to (START, last rdy, go falling).
  typedef enum int {P_INIT, P_START, P_CAL, P_RUN, P_ERR} phase_t;
  phase_t ph;
  int     age, since_rdy, since_fall;
  bit     go_seen, fus;

  function automatic logic [5:0] obs();
    return {bus.strt_cal, bus.moving, bus.en_fusion, bus.cal_busy, bus.cal_err, bus.hdg_vld};
  endfunction

  function automatic logic [5:0] expd();
    return {ph == P_START,
            (ph == P_RUN) && go_seen && (since_fall < COAST),
            fus,
            ph == P_CAL,
            ph == P_ERR,
            (ph == P_RUN) && (since_rdy < STALE)};
  endfunction

  task automatic chk(input string tag, input int o, input int e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, o, e);
    end
  endtask

  task automatic model_reset();
    ph = P_INIT; age = 0; since_rdy = 0; since_fall = 0; go_seen = 0; fus = 0;
  endtask

  task automatic model_step();
    bit g, r, cr, cd, gok;
    int spd;
    g = bus.go; r = bus.rdy; cr = bus.cal_req; cd = bus.cal_done; gok = bus.gyro_ok;
    spd = int'(bus.frwrd_spd);
    case (ph)
      P_INIT:  if (gok) begin ph = P_START; age = 0; end
      P_START: begin ph = P_CAL; age = age + 1; end
      P_CAL: begin
        if (cd) begin
          ph = P_RUN; since_rdy = 0; go_seen = 0; since_fall = 0; fus = 0;
        end else if (age + 1 >= TMO) ph = P_ERR;
        else age = age + 1;
      end
      P_RUN: begin
        if (cr) begin
          ph = P_START; age = 0; fus = 0; go_seen = 0; since_fall = 0;
        end else begin
          since_rdy = r ? 0 : since_rdy + 1;
          if (g) begin go_seen = 1; since_fall = 0; end
          else if (r) since_fall = since_fall + 1;
          if (!g) fus = 0;
          else if (spd >= FON) fus = 1;
          else if (spd < FOFF) fus = 0;
        end
      end
      P_ERR: if (cr) begin ph = P_START; age = 0; end
      default: ph = P_INIT;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    chk("outputs", int'(obs()), int'(expd()));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rdy_pulse_after(input int idle);
    ticks(idle);
    bus.rdy = 1'b1;
    tick();
    bus.rdy = 1'b0;
  endtask

  initial begin
    int k_err;
    bus.gyro_ok = 1'b0; bus.cal_req = 1'b0; bus.go = 1'b0;
    bus.frwrd_spd = '0; bus.cal_done = 1'b0; bus.rdy = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk("reset_state", int'(obs()), 0);
    rst = 1'b0;
    cyc = 0;

    // power-up: cal_req ignored before gyro_ok, then auto-calibration
    ticks(4);
    bus.cal_req = 1'b1; tick(); bus.cal_req = 1'b0;
    chk("init_ignores_cal_req", int'(bus.strt_cal), 0);
    ticks(4);
    bus.gyro_ok = 1'b1; tick();
    chk("pwr_strt_cal", int'(bus.strt_cal), 1);
    tick();
    chk("pwr_strt_once", int'(bus.strt_cal), 0);
    chk("pwr_cal_busy", int'(bus.cal_busy), 1);
    ticks(10);
    bus.cal_req = 1'b1; tick(); bus.cal_req = 1'b0;
    chk("cal_ignores_cal_req", int'(bus.cal_busy), 1);
    ticks(49 - cyc);
    bus.cal_done = 1'b1; tick(); bus.cal_done = 1'b0;
    chk("cal_done_hdg_vld", int'(bus.hdg_vld), 1);
    chk("cal_done_busy", int'(bus.cal_busy), 0);

    // fusion hysteresis sweep
    bus.go = 1'b1;
    for (int s = 'h100; s <= 'h200; s += 'h10) begin
      bus.frwrd_spd = 11'(s);
      bus.rdy = ($urandom_range(3) == 0);
      tick();
      chk("fus_sweep", int'(bus.en_fusion), int'(s >= 'h200));
    end
    bus.rdy = 1'b0;
    bus.frwrd_spd = 11'h190; tick(); chk("fus_hold_190", int'(bus.en_fusion), 1);
    bus.frwrd_spd = 11'h17F; tick(); chk("fus_off_17f", int'(bus.en_fusion), 0);
    bus.frwrd_spd = 11'h250; tick(); chk("fus_on_250", int'(bus.en_fusion), 1);
    bus.go = 1'b0;           tick(); chk("fus_go_low", int'(bus.en_fusion), 0);

    // coast: 16 rdy samples after go drops
    bus.go = 1'b1; tick(); bus.go = 1'b0;
    for (int p = 1; p <= COAST; p++) begin
      rdy_pulse_after(19);
      chk("coast_hold", int'(bus.moving), int'(p < COAST));
    end
    // go re-assert after 8 pulses restarts the full window
    bus.go = 1'b1; tick(); bus.go = 1'b0;
    for (int p = 0; p < 8; p++) rdy_pulse_after(19);
    bus.go = 1'b1; ticks(2); bus.go = 1'b0;
    for (int p = 1; p <= COAST; p++) begin
      rdy_pulse_after(19);
      if (p >= COAST - 1) chk("coast_reload", int'(bus.moving), int'(p < COAST));
    end

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(19) == 0) bus.go = ~bus.go;
      bus.frwrd_spd = 11'($urandom_range('h150, 'h230));
      bus.rdy      = ($urandom_range(4) == 0);
      bus.cal_req  = ($urandom_range(150) == 0);
      bus.cal_done = ($urandom_range(25) == 0);
      tick();
    end
    bus.go = 1'b0; bus.rdy = 1'b0; bus.cal_done = 1'b0;
    bus.cal_req = 1'b1; tick(); bus.cal_req = 1'b0;
    tick();
    bus.cal_done = 1'b1; tick(); bus.cal_done = 1'b0;
    chk("recover_run", int'(bus.hdg_vld), 1);

    // stale watchdog
    bus.rdy = 1'b1; tick(); bus.rdy = 1'b0;
    ticks(STALE - 1);
    chk("stale_before", int'(bus.hdg_vld), 1);
    tick();
    chk("stale_drop", int'(bus.hdg_vld), 0);
    ticks(20);
    chk("stale_hold", int'(bus.hdg_vld), 0);
    bus.rdy = 1'b1; tick(); bus.rdy = 1'b0;
    chk("stale_restore", int'(bus.hdg_vld), 1);

    // calibration timeout and recovery from ERR
    bus.cal_req = 1'b1; tick(); bus.cal_req = 1'b0;
    chk("tmo_strt_cal", int'(bus.strt_cal), 1);
    chk("tmo_hdg_cleared", int'(bus.hdg_vld), 0);
    k_err = 0;
    for (int k = 1; k <= TMO + 5 && k_err == 0; k++) begin
      tick();
      if (bus.cal_err) k_err = k;
    end
    chk("tmo_latency", k_err, TMO);
    ticks(3);
    chk("err_sticky", int'(bus.cal_err), 1);
    bus.cal_req = 1'b1; tick(); bus.cal_req = 1'b0;
    chk("err_restart", int'(bus.strt_cal), 1);
    chk("err_cleared", int'(bus.cal_err), 0);

    // cal_done coincident with the timeout edge wins
    ticks(TMO - 1);
    bus.cal_done = 1'b1; tick(); bus.cal_done = 1'b0;
    chk("simul_no_err", int'(bus.cal_err), 0);
    chk("simul_run", int'(bus.hdg_vld), 1);

    // async reset mid-coast
    bus.go = 1'b1; tick(); bus.go = 1'b0;
    bus.rdy = 1'b1; tick(); bus.rdy = 1'b0;
    ticks(3);
    chk("pre_rst_moving", int'(bus.moving), 1);
    #2 rst = 1'b1;
    model_reset();
    #1 chk("rst_mid_coast", int'(obs()), 0);
    bus.gyro_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // async reset mid-calibration, then no strt_cal until gyro_ok returns
    bus.gyro_ok = 1'b1; ticks(12); bus.gyro_ok = 1'b0;
    chk("pre_rst_cal", int'(bus.cal_busy), 1);
    #2 rst = 1'b1;
    model_reset();
    #1 chk("rst_mid_cal", int'(obs()), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ticks(20);
    chk("no_strt_wo_gyro", int'(bus.strt_cal), 0);
    bus.gyro_ok = 1'b1; tick();
    chk("strt_after_gyro", int'(bus.strt_cal), 1);
    ticks(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
